// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles the two master request ports and the shared slave bus for bus_arbiter.
//   m0*/m1*  : per-master request (Req/We/Addr/WData/Strb) and response
//              (Ready/RData/Err)
//   bus*     : shared slave access (Sel/We/Addr/WData/Strb out, RData/Ready in)
// Modports:
//   slave  - the arbiter's view: it serves the masters and drives the bus
//   master - the environment's view: the masters plus the memory slave
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0Req,   m1Req;
  logic          m0We,    m1We;
  logic [AW-1:0] m0Addr,  m1Addr;
  logic [DW-1:0] m0WData, m1WData;
  logic [2:0]    m0Strb,  m1Strb;
  logic          m0Ready, m1Ready;
  logic [DW-1:0] m0RData, m1RData;
  logic          m0Err,   m1Err;

  logic          busSel;
  logic          busWe;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busWData;
  logic [2:0]    busStrb;
  logic [DW-1:0] busRData;
  logic          busReady;

  modport slave (
    input  m0Req, m1Req, m0We, m1We, m0Addr, m1Addr,
    input  m0WData, m1WData, m0Strb, m1Strb,
    output m0Ready, m1Ready, m0RData, m1RData, m0Err, m1Err,
    output busSel, busWe, busAddr, busWData, busStrb,
    input  busRData, busReady
  );

  modport master (
    output m0Req, m1Req, m0We, m1We, m0Addr, m1Addr,
    output m0WData, m1WData, m0Strb, m1Strb,
    input  m0Ready, m1Ready, m0RData, m1RData, m0Err, m1Err,
    input  busSel, busWe, busAddr, busWData, busStrb,
    output busRData, busReady
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter between two bus masters (m0 = CPU load/store port,
// m1 = DMA-style master) and one shared memory/peripheral bus. One transaction
// is in flight at a time; the granted master owns the bus until busReady.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous, active-high
//   bif    - bus_arbiter_if.slave: master requests/responses and the slave bus
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the watchdog that
// aborts a transaction (Ready + Err) after TIMEOUT ACCESS cycles without
// busReady. Without it mxErr is tied low and ACCESS waits indefinitely.
module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bif
);

  if (AW < 1 || DW < 1 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("bus_arbiter: illegal parameter value");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, stateNext;
  logic   grant, grantNext;          // 0 = m0, 1 = m1
  logic   lastGrant, lastGrantNext;  // resets to 1 so m0 wins the first tie
  logic   timeoutHit;
  logic   finish;                    // transaction ends this cycle

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdCnt, wdCntNext;
`endif

  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    lastGrantNext = lastGrant;
    timeoutHit    = 1'b0;
    finish        = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    wdCntNext     = wdCnt;
`endif

    bif.busSel   = 1'b0;
    bif.busWe    = 1'b0;
    bif.busAddr  = '0;
    bif.busWData = '0;
    bif.busStrb  = 3'b000;
    bif.m0Ready  = 1'b0;
    bif.m1Ready  = 1'b0;
    bif.m0RData  = '0;
    bif.m1RData  = '0;
    bif.m0Err    = 1'b0;
    bif.m1Err    = 1'b0;

    case (state)
      IDLE: begin
`ifdef BUS_ARB_TIMEOUT_EN
        wdCntNext = 8'd0;  // watchdog starts fresh on every ACCESS entry
`endif
        if (bif.m0Req && bif.m1Req) begin
          grantNext = ~lastGrant;
          stateNext = ACCESS;
        end else if (bif.m0Req) begin
          grantNext = 1'b0;
          stateNext = ACCESS;
        end else if (bif.m1Req) begin
          grantNext = 1'b1;
          stateNext = ACCESS;
        end
      end

      ACCESS: begin
        bif.busSel   = 1'b1;
        bif.busWe    = grant ? bif.m1We    : bif.m0We;
        bif.busAddr  = grant ? bif.m1Addr  : bif.m0Addr;
        bif.busWData = grant ? bif.m1WData : bif.m0WData;
        bif.busStrb  = grant ? bif.m1Strb  : bif.m0Strb;

`ifdef BUS_ARB_TIMEOUT_EN
        // A slave completion in the limit cycle wins over the abort.
        timeoutHit = !bif.busReady && (wdCnt == WD_LAST);
        if (!bif.busReady) begin
          wdCntNext = wdCnt + 8'd1;
        end
`endif
        finish = bif.busReady || timeoutHit;

        if (finish) begin
          stateNext     = IDLE;
          lastGrantNext = grant;
          if (grant) begin
            bif.m1Ready = 1'b1;
            bif.m1RData = bif.busReady ? bif.busRData : '0;
            bif.m1Err   = timeoutHit;
          end else begin
            bif.m0Ready = 1'b1;
            bif.m0RData = bif.busReady ? bif.busRData : '0;
            bif.m0Err   = timeoutHit;
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      lastGrant <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      wdCnt     <= 8'd0;
`endif
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastGrantNext;
`ifdef BUS_ARB_TIMEOUT_EN
      wdCnt     <= wdCntNext;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// master/slave traffic, compared every cycle against a transaction-level
// reference model (owner of the bus, cycles spent in the transaction, last
// winner). Define BUS_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_bus_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int MAXW    = 6;
`else
  localparam int MAXW    = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif.slave)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Master-side transaction registers (what each master currently presents)
  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [2:0]  strb[2];

  // Reference model state
  int   mOwner;     // -1 = bus free, else index of master being served
  int   mCnt;       // ACCESS cycles already spent on the current transaction
  logic mLast;      // winner of the previous completed transaction
  int   slaveWaits; // wait cycles the slave inserts for the current transaction
  int   fixedWaits; // -1 = random per transaction
  logic fixedData;
  logic [31:0] dataVal;
  int   cyc;

  // Observed outputs of the most recent step
  logic        obsSel, obsWe;
  logic [31:0] obsAddr, obsWData;
  logic [2:0]  obsStrb;
  logic        obsRdy[2], obsErr[2];
  logic [31:0] obsRd[2];
  int          rdyCyc[$];
  int          rdyWho[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic raise(input int x);
    req[x]   = 1'b1;
    we[x]    = 1'($urandom_range(0, 1));
    addr[x]  = $urandom;
    wdata[x] = $urandom;
    strb[x]  = 3'($urandom_range(0, 7));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step();
    logic        eSel, eWe;
    logic [31:0] eAddr, eWData;
    logic [2:0]  eStrb;
    logic        eRdy[2], eErr[2];
    logic [31:0] eRd[2];
    logic        finished;
    int          g;

    bif.m0Req = req[0]; bif.m0We = we[0]; bif.m0Addr = addr[0];
    bif.m0WData = wdata[0]; bif.m0Strb = strb[0];
    bif.m1Req = req[1]; bif.m1We = we[1]; bif.m1Addr = addr[1];
    bif.m1WData = wdata[1]; bif.m1Strb = strb[1];
    if (mOwner >= 0)
      bif.busReady = !reset && (mCnt == slaveWaits);
    else
      bif.busReady = 1'($urandom_range(0, 1));  // must be ignored while idle
    bif.busRData = fixedData ? dataVal : $urandom;
    #1;

    eSel = 1'b0; eWe = 1'b0; eAddr = '0; eWData = '0; eStrb = '0;
    eRdy = '{1'b0, 1'b0}; eErr = '{1'b0, 1'b0}; eRd = '{32'h0, 32'h0};
    finished = 1'b0;
    g = mOwner;
    if (g >= 0) begin
      eSel = 1'b1; eWe = we[g]; eAddr = addr[g]; eWData = wdata[g]; eStrb = strb[g];
      if (bif.busReady) begin
        finished = 1'b1; eRdy[g] = 1'b1; eRd[g] = bif.busRData;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (mCnt == TIMEOUT - 1) begin
        finished = 1'b1; eRdy[g] = 1'b1; eErr[g] = 1'b1;
      end
`endif
    end

    check("busSel",   bif.busSel,   eSel);
    check("busWe",    bif.busWe,    eWe);
    check("busAddr",  bif.busAddr,  eAddr);
    check("busWData", bif.busWData, eWData);
    check("busStrb",  bif.busStrb,  eStrb);
    check("m0Ready",  bif.m0Ready,  eRdy[0]);
    check("m0RData",  bif.m0RData,  eRd[0]);
    check("m0Err",    bif.m0Err,    eErr[0]);
    check("m1Ready",  bif.m1Ready,  eRdy[1]);
    check("m1RData",  bif.m1RData,  eRd[1]);
    check("m1Err",    bif.m1Err,    eErr[1]);

    obsSel = bif.busSel; obsWe = bif.busWe; obsAddr = bif.busAddr;
    obsWData = bif.busWData; obsStrb = bif.busStrb;
    obsRdy[0] = bif.m0Ready; obsRdy[1] = bif.m1Ready;
    obsRd[0] = bif.m0RData;  obsRd[1] = bif.m1RData;
    obsErr[0] = bif.m0Err;   obsErr[1] = bif.m1Err;
    if (bif.m0Ready || bif.m1Ready) begin
      rdyCyc.push_back(cyc);
      rdyWho.push_back(bif.m1Ready ? 1 : 0);
    end

    if (finished)
      $display("[TB] t=%0d m%0d %s addr=%08h wdata=%08h strb=%0d rdata=%08h err=%0d",
               cyc, g, we[g] ? "WR" : "RD", addr[g], wdata[g], strb[g],
               eRd[g], eErr[g]);

    // Advance the model
    if (reset) begin
      mOwner = -1; mLast = 1'b1; mCnt = 0;
    end else if (mOwner >= 0) begin
      if (finished) begin
        mLast = 1'(mOwner); req[mOwner] = 1'b0; mOwner = -1;
      end else begin
        mCnt++;
      end
    end else if (req[0] || req[1]) begin
      if (req[0] && req[1]) mOwner = mLast ? 0 : 1;
      else                  mOwner = req[0] ? 0 : 1;
      mCnt = 0;
      slaveWaits = (fixedWaits >= 0) ? fixedWaits : $urandom_range(0, MAXW);
    end

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int expCyc[4];
    int expWho[4];
    int t0;
    expCyc = '{1, 3, 5, 7};
    expWho = '{0, 1, 0, 1};

    for (int x = 0; x < 2; x++) begin
      req[x] = 1'b0; we[x] = 1'b0; addr[x] = '0; wdata[x] = '0; strb[x] = '0;
    end
    bif.m0Req = 1'b0; bif.m1Req = 1'b0; bif.m0We = 1'b0; bif.m1We = 1'b0;
    bif.m0Addr = '0; bif.m1Addr = '0; bif.m0WData = '0; bif.m1WData = '0;
    bif.m0Strb = '0; bif.m1Strb = '0; bif.busRData = '0; bif.busReady = 1'b0;
    mOwner = -1; mCnt = 0; mLast = 1'b1; slaveWaits = 0;
    fixedWaits = -1; fixedData = 1'b0; dataVal = '0; cyc = 0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busSel",   bif.busSel,   1'b0);
    check("rst_busWe",    bif.busWe,    1'b0);
    check("rst_busAddr",  bif.busAddr,  32'h0);
    check("rst_busWData", bif.busWData, 32'h0);
    check("rst_busStrb",  bif.busStrb,  3'b000);
    check("rst_m0Ready",  bif.m0Ready,  1'b0);
    check("rst_m1Ready",  bif.m1Ready,  1'b0);
    check("rst_m0RData",  bif.m0RData,  32'h0);
    check("rst_m1RData",  bif.m1RData,  32'h0);
    check("rst_m0Err",    bif.m0Err,    1'b0);
    check("rst_m1Err",    bif.m1Err,    1'b0);
    reset = 1'b0;

    // Zero-wait m0 read
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0010; wdata[0] = '0; strb[0] = 3'b010;
    fixedWaits = 0; fixedData = 1'b1; dataVal = 32'hDEAD_BEEF;
    step();
    step();
    check("tp1_busSel",  obsSel,    1'b1);
    check("tp1_m0Ready", obsRdy[0], 1'b1);
    check("tp1_m0RData", obsRd[0],  32'hDEAD_BEEF);
    step();
    check("tp1_idle",    obsSel,    1'b0);

    // Contention from reset: alternate m0, m1, m0, m1
    doReset();
    fixedData = 1'b0;
    rdyCyc.delete(); rdyWho.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      for (int x = 0; x < 2; x++) if (!req[x]) raise(x);
      step();
    end
    check("tp2_count", rdyCyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rdyCyc.size()) begin
        check("tp2_cycle", rdyCyc[i] - t0, expCyc[i]);
        check("tp2_who",   rdyWho[i],      expWho[i]);
      end
    end

    // m1 write with 3 slave wait cycles
    req[0] = 1'b0; req[1] = 1'b0;
    doReset();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h100; wdata[1] = 32'h1234_5678; strb[1] = 3'b010;
    fixedWaits = 3;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("tp3_busWe",    obsWe,     1'b1);
      check("tp3_busAddr",  obsAddr,   32'h100);
      check("tp3_busWData", obsWData,  32'h1234_5678);
      check("tp3_busStrb",  obsStrb,   3'b010);
      check("tp3_m1Ready",  obsRdy[1], i == 3);
    end

    // Reset in the 2nd wait cycle of an m0 access
    doReset();
    raise(0); we[0] = 1'b0;
    fixedWaits = 6;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    raise(1);
    fixedWaits = 0;
    step();
    check("tp4_busSel",  obsSel,    1'b0);
    check("tp4_busAddr", obsAddr,   32'h0);
    check("tp4_m0Ready", obsRdy[0], 1'b0);
    check("tp4_m1Ready", obsRdy[1], 1'b0);
    step();
    check("tp4_tie_m0",  obsRdy[0], 1'b1);
    for (int i = 0; i < 6 && (req[0] || req[1] || mOwner >= 0); i++) step();

`ifdef BUS_ARB_TIMEOUT_EN
    // Slave never ready: watchdog abort on the 4th ACCESS cycle
    req[0] = 1'b0; req[1] = 1'b0;
    doReset();
    raise(0);
    fixedWaits = 1000; fixedData = 1'b1; dataVal = 32'hAAAA_5555;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("tp5_m0Ready", obsRdy[0], i == 3);
    end
    check("tp5_m0Err",   obsErr[0], 1'b1);
    check("tp5_m0RData", obsRd[0],  32'h0);
    raise(1);
    fixedWaits = 0;
    step();
    step();
    check("tp5_m1Ready", obsRdy[1], 1'b1);
    check("tp5_m1Err",   obsErr[1], 1'b0);

    // busReady first asserted in the limit cycle: normal completion
    raise(0);
    fixedWaits = 3; dataVal = 32'hCAFE_F00D;
    step();
    for (int i = 0; i < 4; i++) step();
    check("tp6_m0Ready", obsRdy[0], 1'b1);
    check("tp6_m0Err",   obsErr[0], 1'b0);
    check("tp6_m0RData", obsRd[0],  32'hCAFE_F00D);
`endif

    // Random traffic
    fixedWaits = -1; fixedData = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int x = 0; x < 2; x++)
        if (!req[x] && $urandom_range(0, 2) == 0) raise(x);
      reset = ($urandom_range(0, 199) == 0) &&
              (mOwner < 0 || (mCnt < slaveWaits && mCnt < TIMEOUT - 1));
      step();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
    $finish;
  end

endmodule
